// File: rtl/unpack_pkg.sv
// Shared constants, FSM state type and width helper for the symbol unpacker.
package unpack_pkg;

   localparam int unsigned SYM_W = 2;
   localparam logic [SYM_W-1:0] IDLE_SYM = 2'd0;

   typedef enum logic {
      StIdle,
      StShift
   } state_e;

   // Width needed to hold a symbol count from 0 to syms inclusive.
   function automatic int unsigned cnt_w(input int unsigned syms);
      return $clog2(syms + 1);
   endfunction

endpackage

// File: rtl/symbol_unpacker_if.sv
// Word-in / symbol-out bus of the symbol unpacker; master is the word producer side.
interface symbol_unpacker_if
   import unpack_pkg::*;
#(
   parameter int unsigned SYMS_PER_WORD = 8
);

   localparam int unsigned CNT_W = cnt_w(SYMS_PER_WORD);

   logic [SYMS_PER_WORD*SYM_W-1:0] in_data;
   logic [CNT_W-1:0]               in_count;
   logic                           in_valid;
   logic                           in_ready;
   logic [SYM_W-1:0]               num;
   logic                           num_valid;
   logic                           sym_last;

   modport master (
      output in_data,
      output in_count,
      output in_valid,
      input  in_ready,
      input  num,
      input  num_valid,
      input  sym_last
   );

   modport slave (
      input  in_data,
      input  in_count,
      input  in_valid,
      output in_ready,
      output num,
      output num_valid,
      output sym_last
   );

endinterface

// File: rtl/sym_select.sv
// Combinational pick of symbol idx_i from a packed word.
// UNPACK_MSB_FIRST_EN: when defined, index 0 is the top symbol and indices descend.
module sym_select
   import unpack_pkg::*;
#(
   parameter int unsigned SYMS_PER_WORD = 8,
   localparam int unsigned IDX_W = $clog2(SYMS_PER_WORD)
) (
   input  logic [SYMS_PER_WORD*SYM_W-1:0] word_i,
   input  logic [IDX_W-1:0]               idx_i,
   output logic [SYM_W-1:0]               sym_o
);

   always_comb begin
      sym_o = IDLE_SYM;
      for (int unsigned i = 0; i < SYMS_PER_WORD; i++) begin
         if (idx_i == IDX_W'(i)) begin
`ifdef UNPACK_MSB_FIRST_EN
            sym_o = word_i[(SYMS_PER_WORD-1-i)*SYM_W +: SYM_W];
`else
            sym_o = word_i[i*SYM_W +: SYM_W];
`endif
         end
      end
   end

endmodule

// File: rtl/symbol_unpacker.sv
// Unpacks words of 2-bit symbols into a one-symbol-per-clock stream for the sequence detector.
// Symbol order is LSB-first unless UNPACK_MSB_FIRST_EN is defined (handled in sym_select).
module symbol_unpacker
   import unpack_pkg::*;
#(
   parameter int unsigned SYMS_PER_WORD = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   symbol_unpacker_if.slave   bus
);

   localparam int unsigned CNT_W  = cnt_w(SYMS_PER_WORD);
   localparam int unsigned IDX_W  = $clog2(SYMS_PER_WORD);
   localparam int unsigned WORD_W = SYMS_PER_WORD * SYM_W;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WORD_W-1:0]  word_q, word_d;
   logic [SYM_W-1:0]   num_q, num_d;
   logic               num_valid_q, num_valid_d;
   logic               sym_last_q, sym_last_d;

   logic               in_ready;
   logic               accept;
   logic [CNT_W-1:0]   cnt_eff;
   logic [WORD_W-1:0]  sel_word;
   logic [IDX_W-1:0]   sel_idx;
   logic [SYM_W-1:0]   sel_sym;

   assign in_ready = (state_q == StIdle) || (rem_q == CNT_W'(1));
   assign accept   = bus.in_valid && in_ready;

   // On acceptance the first symbol comes straight from the incoming word.
   assign sel_word = accept ? bus.in_data : word_q;
   assign sel_idx  = accept ? '0 : idx_q;

   sym_select #(
      .SYMS_PER_WORD (SYMS_PER_WORD)
   ) u_sym_select (
      .word_i (sel_word),
      .idx_i  (sel_idx),
      .sym_o  (sel_sym)
   );

   always_comb begin
      cnt_eff = bus.in_count;
      if (bus.in_count == '0 || bus.in_count > CNT_W'(SYMS_PER_WORD)) begin
         cnt_eff = CNT_W'(SYMS_PER_WORD);
      end
   end

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      idx_d       = idx_q;
      word_d      = word_q;
      num_d       = num_q;
      num_valid_d = num_valid_q;
      sym_last_d  = sym_last_q;

      if (accept) begin
         state_d     = StShift;
         word_d      = bus.in_data;
         rem_d       = cnt_eff;
         idx_d       = IDX_W'(1);
         num_d       = sel_sym;
         num_valid_d = 1'b1;
         sym_last_d  = (cnt_eff == CNT_W'(1));
      end else if (state_q == StShift) begin
         if (rem_q > CNT_W'(1)) begin
            num_d      = sel_sym;
            idx_d      = idx_q + IDX_W'(1);
            rem_d      = rem_q - CNT_W'(1);
            sym_last_d = (rem_q == CNT_W'(2));
         end else begin
            state_d     = StIdle;
            rem_d       = '0;
            idx_d       = '0;
            num_d       = IDLE_SYM;
            num_valid_d = 1'b0;
            sym_last_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rem_q       <= '0;
         idx_q       <= '0;
         word_q      <= '0;
         num_q       <= IDLE_SYM;
         num_valid_q <= 1'b0;
         sym_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         idx_q       <= idx_d;
         word_q      <= word_d;
         num_q       <= num_d;
         num_valid_q <= num_valid_d;
         sym_last_q  <= sym_last_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.num       = num_q;
   assign bus.num_valid = num_valid_q;
   assign bus.sym_last  = sym_last_q;

endmodule

// File: tb/tb_symbol_unpacker.sv
// Scoreboard bench for symbol_unpacker: driver pushes expected symbols, negedge monitor pops.
module tb_symbol_unpacker;
   import unpack_pkg::*;

   localparam int unsigned SPW = 8;
   localparam int unsigned DW  = SPW * SYM_W;
   localparam int unsigned CW  = cnt_w(SPW);

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   // Each entry: {last, symbol}
   logic [SYM_W:0] exp_q[$];

   symbol_unpacker_if #(.SYMS_PER_WORD(SPW)) bus ();

   symbol_unpacker #(
      .SYMS_PER_WORD (SPW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d at t=%0t", name, act, req, $time);
   endtask

   // Reference: a word yields n symbols, n = count, or the full word when count is 0 or too big.
   function automatic void push_word(input logic [DW-1:0] d, input int c);
      int n;
      n = (c == 0 || c > int'(SPW)) ? int'(SPW) : c;
      for (int i = 0; i < n; i++) begin
         int pos;
         logic [SYM_W-1:0] s;
`ifdef UNPACK_MSB_FIRST_EN
         pos = int'(SPW) - 1 - i;
`else
         pos = i;
`endif
         s = SYM_W'((d >> (SYM_W * pos)) & 'h3);
         exp_q.push_back({(i == n - 1), s});
      end
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         logic [SYM_W:0] e;
         check("in_ready", int'(bus.in_ready), int'(exp_q.size() <= 1));
         if (bus.num_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_symbol", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("num", int'(bus.num), int'(e[SYM_W-1:0]));
               check("sym_last", int'(bus.sym_last), int'(e[SYM_W]));
            end
         end else begin
            check("idle_num", int'(bus.num), int'(IDLE_SYM));
            check("idle_last", int'(bus.sym_last), 0);
            check("bubble_pending", exp_q.size(), 0);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge with in_valid still high.
   task automatic send(input logic [DW-1:0] d, input int c);
      int waited;
      waited       = 0;
      bus.in_data  = d;
      bus.in_count = CW'(c);
      bus.in_valid = 1'b1;
      while (!bus.in_ready && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         check("accept_timeout", 0, 1);
         bus.in_valid = 1'b0;
      end else begin
         @(posedge clk);
         push_word(d, c);
         @(negedge clk);
      end
   endtask

   // Deassert valid and scramble the data lines, which must be ignored.
   task automatic idle(input int k);
      bus.in_valid = 1'b0;
      bus.in_data  = DW'($urandom);
      bus.in_count = CW'($urandom);
      repeat (k) @(negedge clk);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_count = '0;
      #1;
      check("rst_num", int'(bus.num), int'(IDLE_SYM));
      check("rst_num_valid", int'(bus.num_valid), 0);
      check("rst_sym_last", int'(bus.sym_last), 0);
      check("rst_in_ready", int'(bus.in_ready), 1);
      #21;
      rst_n = 1'b1;
      @(negedge clk);

      send(16'hE4E4, 8);
      idle(12);
      send(16'h0039, 3);
      idle(6);
      send(16'h0039, 3);
      send(16'h0002, 1);
      idle(6);
      send(16'h5555, 0);
      idle(10);
      send(16'h5555, 9);
      idle(10);
`ifdef UNPACK_MSB_FIRST_EN
      send(16'h6C00, 3);
      idle(6);
`endif

      // Reset while the fourth symbol is on num.
      send(16'hE4E4, 8);
      idle(2);
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("pre_reset_num", int'(bus.num), int'(exp_q[0][SYM_W-1:0]));
      else check("pre_reset_queue", 0, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_num", int'(bus.num), int'(IDLE_SYM));
      check("midrst_num_valid", int'(bus.num_valid), 0);
      check("midrst_sym_last", int'(bus.sym_last), 0);
      check("midrst_in_ready", int'(bus.in_ready), 1);
      exp_q.delete();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", int'(bus.in_ready), 1);
      idle(8);

      for (int w = 0; w < 60; w++) begin
         send(DW'($urandom), int'($urandom_range(0, 9)));
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(20);
      check("drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
